mantissa_mul_add: RTL and testbench
===================================

MANTISSA_MUL_ADD -- requirements
Module: mantissa_mul_add

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24, giving the operand width (23-bit fraction plus hidden bit).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, request to begin an operation; sampled only when busy=0.
REQ-005 The block SHALL have port sum_or_mul, input, 1 bit, operation select: 1 = add, 0 = multiply.
REQ-006 The block SHALL have port a, input, WIDTH bits, unsigned operand A (multiplicand).
REQ-007 The block SHALL have port b, input, WIDTH bits, unsigned operand B (multiplier).
REQ-008 The block SHALL have port busy, output, 1 bit, high while an accepted operation is executing.
REQ-009 The block SHALL have port done, output, 1 bit, one-cycle pulse marking result valid.
REQ-010 The block SHALL have port result, output, 2*WIDTH bits, unsigned result, held until next acceptance or reset.

Function
REQ-011 Start SHALL be accepted on an edge where start=1 and busy=0; a, b, sum_or_mul latched internally on that edge; busy=1 from that edge.
REQ-012 start=1 while busy=1 SHALL be ignored; a, b, sum_or_mul changes while busy=1 SHALL not affect the running operation.
REQ-013 The FSM SHALL have states IDLE, EXEC, MUL, DONE; acceptance moves IDLE or DONE to EXEC.
REQ-014 EXEC, add: next edge SHALL load result = zero-extended a+b (WIDTH+1 significant bits, no truncation) and go to DONE.
REQ-015 EXEC, multiply with a=0 or b=0 (zero shortcut): next edge SHALL load result=0 and go to DONE.
REQ-016 EXEC, multiply with b=1 (identity shortcut, a nonzero): next edge SHALL load result = zero-extended a and go to DONE.
REQ-017 EXEC, other multiply: next edge SHALL clear the accumulator, load multiplicand register (2*WIDTH bits) with a, multiplier register with b, and go to MUL.
REQ-018 Each MUL edge SHALL add the multiplicand register to the accumulator if the multiplier LSB=1, shift the multiplicand left by 1, and shift the multiplier right by 1.
REQ-019 MUL SHALL terminate early: on the edge where the shifted multiplier becomes zero, result SHALL load the final accumulator and the state SHALL go to DONE.
REQ-020 Multiply latency SHALL be k MUL edges, k = (index of MSB set in b)+1, maximum WIDTH; the accumulator SHALL never overflow 2*WIDTH bits.
REQ-021 In DONE, done=1 and busy=0 for exactly one cycle; next edge goes to IDLE unless start=1, which is accepted (back-to-back).
REQ-022 done SHALL be low in every state other than DONE; busy SHALL be high in EXEC and MUL only.
REQ-023 result SHALL change only on the edge entering DONE, or on reset.

Reset
REQ-024 On an edge with reset=1, state SHALL go to IDLE and busy=0, done=0, result=0, with internal registers cleared, overriding start, including mid-MUL.
REQ-025 Any operation interrupted by reset SHALL be discarded; no done pulse SHALL follow for it.

Verification
REQ-026 Add: WIDTH=24, a=0xFFFFFF, b=0x000001, sum_or_mul=1 -> done 2 edges after acceptance, result=0x1000000.
REQ-027 Multiply: a=3, b=5 -> one EXEC plus 3 MUL edges, done pulse one cycle, result=15; busy low during done.
REQ-028 Shortcuts: a=0, b=7 -> result=0; a=0x123456, b=1 -> result=0x123456; both done 2 edges after acceptance with no MUL cycles.
REQ-029 Worst case: a=b=0xFFFFFF -> 24 MUL edges, result=0xFFFFFE000001; start pulses during busy ignored, with result unchanged by them.
REQ-030 Back-to-back and reset: start held high through DONE -> second operation accepted in the DONE cycle; reset asserted during a MUL edge -> next cycle busy=0, done=0, result=0, and no later done.

Source files
------------

// File: rtl/mantissa_mul_add.sv
// Unsigned mantissa add / shift-and-add multiply with start/busy/done handshake.
// Multiply exits early once the remaining multiplier bits are all zero.
module mantissa_mul_add #(
    parameter int unsigned WIDTH = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               sum_or_mul,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    typedef enum logic [1:0] {StIdle, StExec, StMul, StDone} state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_op;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_result;

    logic                 w_accept;
    logic                 w_zero;
    logic                 w_one;
    logic                 w_mul_last;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_acc_next;

    assign w_accept   = start && ((r_state == StIdle) || (r_state == StDone));
    assign w_zero     = (r_a == '0) || (r_b == '0);
    assign w_one      = (r_b == WIDTH'(1));
    // Last MUL step: nothing left above the bit being consumed now.
    assign w_mul_last = (r_mplier[WIDTH-1:1] == '0);
    assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    assign busy   = (r_state == StExec) || (r_state == StMul);
    assign done   = (r_state == StDone);
    assign result = r_result;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (start) w_state_next = StExec;
            end
            StExec: begin
                if (r_op || w_zero || w_one) w_state_next = StDone;
                else                         w_state_next = StMul;
            end
            StMul: begin
                if (w_mul_last) w_state_next = StDone;
            end
            StDone: begin
                w_state_next = start ? StExec : StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_a  <= a;
                r_b  <= b;
                r_op <= sum_or_mul;
            end
            case (r_state)
                StExec: begin
                    if (r_op) begin
                        r_result <= {{(WIDTH-1){1'b0}}, w_sum};
                    end else if (w_zero) begin
                        r_result <= '0;
                    end else if (w_one) begin
                        r_result <= {{WIDTH{1'b0}}, r_a};
                    end else begin
                        r_acc    <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, r_a};
                        r_mplier <= r_b;
                    end
                end
                StMul: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (w_mul_last) r_result <= w_acc_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mantissa_mul_add.sv
// Directed bench for mantissa_mul_add: add, multiply, shortcuts, worst case,
// back-to-back acceptance and mid-multiply reset.
module tb_mantissa_mul_add;

    localparam int unsigned WIDTH = 24;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               sum_or_mul = 1'b0;
    logic [WIDTH-1:0]   a = '0;
    logic [WIDTH-1:0]   b = '0;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    mantissa_mul_add #(.WIDTH(WIDTH)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .sum_or_mul (sum_or_mul),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Edge count includes the acceptance edge; noise pokes start/operands while busy.
    task automatic run_op(input string tag, input bit op, input logic [WIDTH-1:0] va,
                          input logic [WIDTH-1:0] vb, input logic [2*WIDTH-1:0] exp,
                          input int exp_edges, input bit noise);
        logic [2*WIDTH-1:0] prev;
        int n;
        bit bad;
        start = 1'b1; sum_or_mul = op; a = va; b = vb;
        tick();
        start = 1'b0;
        check({tag, "_busy_acc"}, busy, 1);
        prev = result;
        n = 1;
        bad = 1'b0;
        while (!done && n < 200) begin
            if (noise) begin
                start = 1'b1;
                a = WIDTH'($urandom);
                b = WIDTH'($urandom);
                sum_or_mul = 1'($urandom);
            end
            tick();
            n++;
            if (!done && (result !== prev || busy !== 1'b1)) bad = 1'b1;
        end
        start = 1'b0;
        check({tag, "_done"}, done, 1);
        check({tag, "_edges"}, n, exp_edges);
        check({tag, "_hold"}, bad, 0);
        check({tag, "_result"}, result, exp);
        check({tag, "_busy_done"}, busy, 0);
        tick();
        check({tag, "_pulse"}, done, 0);
        check({tag, "_keep"}, result, exp);
    endtask

    initial begin
        int n;
        bit seen;

        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        reset = 1'b0;
        tick();

        run_op("add_carry", 1'b1, 24'hFFFFFF, 24'h000001, 48'h1000000, 2, 1'b0);
        run_op("add_max", 1'b1, 24'hFFFFFF, 24'hFFFFFF, 48'h1FFFFFE, 2, 1'b0);
        run_op("mul_3x5", 1'b0, 24'd3, 24'd5, 48'd15, 5, 1'b0);
        run_op("mul_a0", 1'b0, 24'd0, 24'd7, 48'd0, 2, 1'b0);
        run_op("mul_b1", 1'b0, 24'h123456, 24'd1, 48'h123456, 2, 1'b0);
        run_op("mul_b0", 1'b0, 24'd9, 24'd0, 48'd0, 2, 1'b0);
        run_op("mul_6x7", 1'b0, 24'd6, 24'd7, 48'd42, 5, 1'b0);
        run_op("mul_worst", 1'b0, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 26, 1'b1);

        // Back-to-back: start held through DONE accepts the second operation there.
        start = 1'b1; sum_or_mul = 1'b1; a = 24'd10; b = 24'd20;
        tick();
        n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        check("b2b_first_done", done, 1);
        check("b2b_first_result", result, 30);
        sum_or_mul = 1'b0; a = 24'd6; b = 24'd7;
        tick();
        start = 1'b0;
        check("b2b_accept_busy", busy, 1);
        check("b2b_accept_done", done, 0);
        n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        check("b2b_second_done", done, 1);
        check("b2b_second_result", result, 42);
        tick();

        // Reset in the middle of a long multiply.
        start = 1'b1; sum_or_mul = 1'b0; a = 24'hFFFFFF; b = 24'hFFFFFF;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("rstmid_busy_before", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmid_busy", busy, 0);
        check("rstmid_done", done, 0);
        check("rstmid_result", result, 0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy) seen = 1'b1;
        end
        check("rstmid_no_done", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
